mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_pkg.sv | 26 ++
 rtl/mem_responder_if.sv | 28 ++
 rtl/mem_word_array.sv | 31 +++
 rtl/mem_responder.sv | 152 +++++++++++++++
 tb/tb_mem_responder.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_responder_pkg.sv
// rtl/mem_responder_pkg.sv - shared types and limits for the memory responder
// Purpose: FSM state encoding, counter width, parameter range limits and the
//          counter-load helper used by the responder.
// Ports:   none (package).
package mem_responder_pkg;

   localparam int DATA_W        = 32;
   localparam int STRB_W        = DATA_W / 8;
   localparam int CNT_W         = 4;
   localparam int REQ_DELAY_MAX = 15;
   localparam int RD_LAT_MIN    = 1;
   localparam int RD_LAT_MAX    = 15;

   typedef enum logic [3:0] {
      ST_IDLE = 4'b0001,
      ST_ACPT = 4'b0010,
      ST_LAT  = 4'b0100,
      ST_RESP = 4'b1000
   } state_e;

   // Counters run from N-1 down to 0, so an N-cycle wait loads N-1.
   function automatic logic [CNT_W-1:0] cnt_load(input int cycles);
      return (cycles > 0) ? CNT_W'(cycles - 1) : '0;
   endfunction

endpackage

// File: rtl/mem_responder_if.sv
// rtl/mem_responder_if.sv - request/response bus between initiator and memory responder
// Purpose: groups the request channel (address, write data/strobe, read/write
//          requests, ready) and the read response channel (data, valid, ready).
// Modports: master = initiator side, slave = responder side.
interface mem_responder_if;
   import mem_responder_pkg::*;

   logic [31:0]       Mem_Addr;
   logic              MemWrite;
   logic [DATA_W-1:0] Write_data;
   logic [STRB_W-1:0] Write_strb;
   logic              MemRead;
   logic              Mem_Req_Ready;
   logic [DATA_W-1:0] Read_data;
   logic              Read_data_Valid;
   logic              Read_data_Ready;

   modport master (
      output Mem_Addr, MemWrite, Write_data, Write_strb, MemRead, Read_data_Ready,
      input  Mem_Req_Ready, Read_data, Read_data_Valid
   );

   modport slave (
      input  Mem_Addr, MemWrite, Write_data, Write_strb, MemRead, Read_data_Ready,
      output Mem_Req_Ready, Read_data, Read_data_Valid
   );

endinterface

// File: rtl/mem_word_array.sv
// rtl/mem_word_array.sv - word RAM with per-byte write strobes and combinational read
// Purpose: 2^ADDR_WIDTH x 32-bit storage, written on the rising edge, read asynchronously.
// Ports:   clk_i clock; we_i/waddr_i/wdata_i/wstrb_i write port;
//          raddr_i/rdata_o read port. Contents are never reset.
module mem_word_array
   import mem_responder_pkg::*;
#(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk_i,
   input  logic                  we_i,
   input  logic [ADDR_WIDTH-1:0] waddr_i,
   input  logic [DATA_W-1:0]     wdata_i,
   input  logic [STRB_W-1:0]     wstrb_i,
   input  logic [ADDR_WIDTH-1:0] raddr_i,
   output logic [DATA_W-1:0]     rdata_o
);

   logic [DATA_W-1:0] mem_q [0:(1<<ADDR_WIDTH)-1];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         for (int i = 0; i < STRB_W; i++) begin
            if (wstrb_i[i]) mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
         end
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - single-outstanding memory responder with programmable accept delay and read latency
// Purpose: accepts one read or write at a time; writes merge byte lanes into the
//          word array in the accept cycle, reads return the word RD_LAT cycles
//          after accept and hold it until the initiator takes it.
// Ports:   clk   rising-edge clock
//          rst   synchronous active-high reset
//          mem_if  slave side of mem_responder_if (request + read response)
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int ADDR_WIDTH = 10,
   parameter int REQ_DELAY  = 0,
   parameter int RD_LAT     = 1
) (
   input logic            clk,
   input logic            rst,
   mem_responder_if.slave mem_if
);

   // Out-of-range parameters are clamped to the supported window.
   localparam int DLY_EFF = (REQ_DELAY > REQ_DELAY_MAX) ? REQ_DELAY_MAX :
                            (REQ_DELAY < 0) ? 0 : REQ_DELAY;
   localparam int LAT_EFF = (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX :
                            (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN : RD_LAT;

   localparam logic [CNT_W-1:0] DLY_LOAD = cnt_load(DLY_EFF);
   localparam logic [CNT_W-1:0] LAT_LOAD = cnt_load(LAT_EFF);

   state_e                  state_q, state_d;
   logic [CNT_W-1:0]        dly_q, dly_d;
   logic [CNT_W-1:0]        lat_q, lat_d;
   logic [ADDR_WIDTH-1:0]   raddr_q, raddr_d;
   logic [DATA_W-1:0]       rdata_q, rdata_d;

   logic                    req;
   logic                    ready;
   logic                    valid;
   logic                    mem_we;
   logic [ADDR_WIDTH-1:0]   bus_idx;
   logic [ADDR_WIDTH-1:0]   mem_raddr;
   logic [DATA_W-1:0]       mem_rdata;
   logic                    addr_unused;

   assign req     = mem_if.MemRead | mem_if.MemWrite;
   assign bus_idx = mem_if.Mem_Addr[ADDR_WIDTH+1:2];

   // Byte offset and bits above the array depth do not select a word.
   assign addr_unused = ^{mem_if.Mem_Addr[31:ADDR_WIDTH+2], mem_if.Mem_Addr[1:0]};

   // While waiting out the latency the bus may already carry the next
   // request, so the read port must use the latched word address.
   assign mem_raddr = (state_q == ST_LAT) ? raddr_q : bus_idx;

   always_comb begin
      state_d = state_q;
      dly_d   = dly_q;
      lat_d   = lat_q;
      raddr_d = raddr_q;
      rdata_d = rdata_q;
      ready   = 1'b0;
      valid   = 1'b0;
      mem_we  = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            ready = (DLY_EFF == 0);
            if (req && (DLY_EFF != 0)) begin
               dly_d   = DLY_LOAD;
               state_d = ST_ACPT;
            end
         end
         ST_ACPT: begin
            if (!req) begin
               dly_d   = '0;
               state_d = ST_IDLE;
            end else if (dly_q == '0) begin
               ready = 1'b1;
            end else begin
               dly_d = dly_q - 1'b1;
            end
         end
         ST_LAT: begin
            lat_d = lat_q - 1'b1;
            if (lat_q == CNT_W'(1)) begin
               rdata_d = mem_rdata;
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            valid = 1'b1;
            if (mem_if.Read_data_Ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Nothing is accepted or presented in a reset cycle.
      if (rst) begin
         ready = 1'b0;
         valid = 1'b0;
      end

      // Accept: a write wins over a simultaneous read.
      if (ready && req) begin
         if (mem_if.MemWrite) begin
            mem_we  = 1'b1;
            state_d = ST_IDLE;
         end else begin
            raddr_d = bus_idx;
            lat_d   = LAT_LOAD;
            if (LAT_EFF == 1) begin
               rdata_d = mem_rdata;
               state_d = ST_RESP;
            end else begin
               state_d = ST_LAT;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         dly_q   <= '0;
         lat_q   <= '0;
         raddr_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         dly_q   <= dly_d;
         lat_q   <= lat_d;
         raddr_q <= raddr_d;
         rdata_q <= rdata_d;
      end
   end

   mem_word_array #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_mem (
      .clk_i   (clk),
      .we_i    (mem_we),
      .waddr_i (bus_idx),
      .wdata_i (mem_if.Write_data),
      .wstrb_i (mem_if.Write_strb),
      .raddr_i (mem_raddr),
      .rdata_o (mem_rdata)
   );

   assign mem_if.Mem_Req_Ready   = ready;
   assign mem_if.Read_data_Valid = valid;
   assign mem_if.Read_data       = rdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - self-checking bench for mem_responder (two timing configurations)
module tb_mem_responder;

   localparam int AW    = 10;
   localparam int F_DLY = 0;
   localparam int F_LAT = 1;
   localparam int S_DLY = 3;
   localparam int S_LAT = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        sel;
   logic [31:0] addr, wdata;
   logic [3:0]  strb;
   logic        wr, rd, rready;

   always #5 clk = ~clk;

   mem_responder_if if_f ();
   mem_responder_if if_s ();

   assign if_f.Mem_Addr        = addr;
   assign if_f.Write_data      = wdata;
   assign if_f.Write_strb      = strb;
   assign if_f.MemWrite        = wr & ~sel;
   assign if_f.MemRead         = rd & ~sel;
   assign if_f.Read_data_Ready = rready & ~sel;
   assign if_s.Mem_Addr        = addr;
   assign if_s.Write_data      = wdata;
   assign if_s.Write_strb      = strb;
   assign if_s.MemWrite        = wr & sel;
   assign if_s.MemRead         = rd & sel;
   assign if_s.Read_data_Ready = rready & sel;

   wire        ready_m = sel ? if_s.Mem_Req_Ready   : if_f.Mem_Req_Ready;
   wire        valid_m = sel ? if_s.Read_data_Valid : if_f.Read_data_Valid;
   wire [31:0] rdata_m = sel ? if_s.Read_data       : if_f.Read_data;

   mem_responder #(.ADDR_WIDTH(AW), .REQ_DELAY(F_DLY), .RD_LAT(F_LAT)) u_fast (
      .clk(clk), .rst(rst), .mem_if(if_f));
   mem_responder #(.ADDR_WIDTH(AW), .REQ_DELAY(S_DLY), .RD_LAT(S_LAT)) u_slow (
      .clk(clk), .rst(rst), .mem_if(if_s));

   int total = 0;
   int bad   = 0;

   // Reference memory per DUT, indexed by word.
   logic [31:0] mdl [0:1][0:1023];

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] s);
      logic [31:0] r;
      r = old;
      for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
      return r;
   endfunction

   function automatic int widx(input logic [31:0] a);
      return int'(a[AW+1:2]);
   endfunction

   function automatic int exp_dly(input bit s);
      return s ? S_DLY : F_DLY;
   endfunction

   function automatic int exp_lat(input bit s);
      return s ? S_LAT : F_LAT;
   endfunction

   // Called at a falling edge; returns at a falling edge after the accept edge.
   task automatic do_write(input bit s, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] st, input bit also_rd,
                           output int wwait, output bit to);
      sel = s; addr = a; wdata = d; strb = st; wr = 1'b1; rd = also_rd;
      #1;
      wwait = 0; to = 1'b0;
      while (!ready_m && wwait < 40) begin @(negedge clk); #1; wwait++; end
      if (!ready_m) begin to = 1'b1; wr = 1'b0; rd = 1'b0; return; end
      @(negedge clk);
      wr = 1'b0; rd = 1'b0;
      mdl[s][widx(a)] = merge(mdl[s][widx(a)], d, st);
   endtask

   // hold = number of valid cycles before the response is taken (min 1).
   task automatic do_read(input bit s, input logic [31:0] a, input int hold,
                          output logic [31:0] data, output int rwait, output int vlat,
                          output bit hold_ok, output bit to);
      sel = s; addr = a; rd = 1'b1; wr = 1'b0; rready = 1'b0;
      #1;
      rwait = 0; vlat = 0; to = 1'b0; hold_ok = 1'b0; data = 'x;
      while (!ready_m && rwait < 40) begin @(negedge clk); #1; rwait++; end
      if (!ready_m) begin to = 1'b1; rd = 1'b0; return; end
      @(negedge clk);
      rd = 1'b0;
      #1;
      vlat = 1;
      while (!valid_m && vlat < 40) begin @(negedge clk); #1; vlat++; end
      if (!valid_m) begin to = 1'b1; return; end
      data    = rdata_m;
      hold_ok = 1'b1;
      for (int i = 1; i < hold; i++) begin
         @(negedge clk); #1;
         if (!valid_m || rdata_m !== data) hold_ok = 1'b0;
      end
      rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
      #1;
      if (valid_m) hold_ok = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; rready = 1'b1; sel = 1'b0; wr = 1'b0; rd = 1'b0;
      addr = '0; wdata = '0; strb = '0;
      repeat (3) @(negedge clk);
      total++; if (if_f.Mem_Req_Ready !== 1'b0) begin bad++; $display("FAIL rst_ready_fast act=%b exp=0", if_f.Mem_Req_Ready); end
      total++; if (if_s.Mem_Req_Ready !== 1'b0) begin bad++; $display("FAIL rst_ready_slow act=%b exp=0", if_s.Mem_Req_Ready); end
      total++; if (if_f.Read_data_Valid !== 1'b0 || if_s.Read_data_Valid !== 1'b0) begin
         bad++; $display("FAIL rst_valid act=%b%b exp=00", if_f.Read_data_Valid, if_s.Read_data_Valid); end
      total++; if (if_f.Read_data !== 32'h0 || if_s.Read_data !== 32'h0) begin
         bad++; $display("FAIL rst_rdata act=%h/%h exp=0", if_f.Read_data, if_s.Read_data); end
      rst = 1'b0;
      #1;
      total++; if (if_f.Mem_Req_Ready !== 1'b1) begin bad++; $display("FAIL post_rst_ready_fast act=%b exp=1", if_f.Mem_Req_Ready); end
      total++; if (if_f.Read_data_Valid !== 1'b0 || if_s.Read_data_Valid !== 1'b0) begin
         bad++; $display("FAIL post_rst_valid act=%b%b exp=00", if_f.Read_data_Valid, if_s.Read_data_Valid); end
      rready = 1'b0;
   endtask

   task automatic test_basic();
      int w, rw, vl; bit to, ok; logic [31:0] d;
      do_write(1'b0, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, w, to);
      total++; if (to || w != 0) begin bad++; $display("FAIL basic_wr_wait act=%0d to=%0d exp=0", w, to); end
      do_read(1'b0, 32'h10, 1, d, rw, vl, ok, to);
      total++; if (to || rw != 0 || vl != 1 || !ok) begin
         bad++; $display("FAIL basic_rd_timing act=rw%0d vl%0d ok%0d to%0d exp=rw0 vl1 ok1 to0", rw, vl, ok, to); end
      total++; if (d !== 32'hDEADBEEF) begin bad++; $display("FAIL basic_rd_data act=%h exp=deadbeef", d); end
   endtask

   task automatic test_strobe();
      int w, rw, vl; bit to, ok; logic [31:0] d;
      do_write(1'b0, 32'h20, 32'h11223344, 4'hF, 1'b0, w, to);
      do_write(1'b0, 32'h20, 32'h0000AA00, 4'b0010, 1'b0, w, to);
      do_read(1'b0, 32'h23, 2, d, rw, vl, ok, to);
      total++; if (to || !ok || d !== 32'h1122AA44) begin
         bad++; $display("FAIL strobe_merge act=%h ok%0d to%0d exp=1122aa44", d, ok, to); end
   endtask

   task automatic test_timing();
      int w, rw, vl; bit to, ok; logic [31:0] d;
      do_write(1'b1, 32'h30, 32'hA5A50F0F, 4'hF, 1'b0, w, to);
      total++; if (to || w != S_DLY) begin bad++; $display("FAIL slow_wr_wait act=%0d exp=%0d", w, S_DLY); end
      do_read(1'b1, 32'h30, 6, d, rw, vl, ok, to);
      total++; if (to || rw != S_DLY) begin bad++; $display("FAIL slow_rd_ready act=%0d exp=%0d", rw, S_DLY); end
      total++; if (vl != S_LAT) begin bad++; $display("FAIL slow_rd_latency act=%0d exp=%0d", vl, S_LAT); end
      total++; if (!ok) begin bad++; $display("FAIL slow_rd_hold act=0 exp=1"); end
      total++; if (d !== 32'hA5A50F0F) begin bad++; $display("FAIL slow_rd_data act=%h exp=a5a50f0f", d); end
   endtask

   task automatic test_both();
      int w, rw, vl; bit to, ok, seen; logic [31:0] d;
      do_write(1'b0, 32'h40, 32'h5, 4'hF, 1'b1, w, to);
      seen = 1'b0;
      repeat (8) begin #1; if (if_f.Read_data_Valid) seen = 1'b1; @(negedge clk); end
      total++; if (to || seen) begin bad++; $display("FAIL both_no_valid act=%0d to%0d exp=0", seen, to); end
      do_read(1'b0, 32'h40, 1, d, rw, vl, ok, to);
      total++; if (to || d !== 32'h5) begin bad++; $display("FAIL both_wr_data act=%h exp=00000005", d); end
   endtask

   task automatic test_reset_abort();
      int w, rw, vl, n; bit to, ok, seen; logic [31:0] d;
      do_write(1'b1, 32'h50, 32'hCAFE0001, 4'hF, 1'b0, w, to);
      // write abandoned while the accept delay is running
      @(negedge clk);
      sel = 1'b1; addr = 32'h50; wdata = 32'hBAD0BAD0; strb = 4'hF; wr = 1'b1;
      @(negedge clk);
      rst = 1'b1; wr = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      // read reset while waiting out the latency
      rd = 1'b1; #1; n = 0;
      while (!if_s.Mem_Req_Ready && n < 40) begin @(negedge clk); #1; n++; end
      total++; if (n != S_DLY) begin bad++; $display("FAIL abort_rd_ready act=%0d exp=%0d", n, S_DLY); end
      @(negedge clk);
      rd = 1'b0; rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      seen = 1'b0;
      repeat (8) begin #1; if (if_s.Read_data_Valid) seen = 1'b1; @(negedge clk); end
      total++; if (seen) begin bad++; $display("FAIL abort_no_valid act=1 exp=0"); end
      do_read(1'b1, 32'h50, 1, d, rw, vl, ok, to);
      total++; if (to || rw != S_DLY || d !== 32'hCAFE0001) begin
         bad++; $display("FAIL abort_mem_kept act=%h rw%0d to%0d exp=cafe0001 rw%0d", d, rw, to, S_DLY); end
   endtask

   task automatic test_wrap();
      int w, rw, vl; bit to, ok; logic [31:0] d;
      do_write(1'b0, 32'h00001004, 32'h77, 4'hF, 1'b0, w, to);
      do_read(1'b0, 32'h00000004, 1, d, rw, vl, ok, to);
      total++; if (to || d !== 32'h77) begin bad++; $display("FAIL wrap_data act=%h exp=00000077", d); end
   endtask

   // Random back-to-back traffic on both configurations against the model.
   task automatic test_random();
      int w, rw, vl; bit to, ok, s; logic [31:0] d, a;
      for (int k = 0; k < 8; k++) begin
         for (int j = 0; j < 2; j++) do_write(j[0], (32'h200 + k) << 2, $urandom, 4'hF, 1'b0, w, to);
      end
      for (int n = 0; n < 60; n++) begin
         s = $urandom_range(0, 1) != 0;
         a = ($urandom & 32'hFFFF_F003) | ((32'h200 + $urandom_range(0, 7)) << 2);
         if ($urandom_range(0, 1) == 0) begin
            do_write(s, a, $urandom, 4'($urandom_range(0, 15)), 1'b0, w, to);
            total++; if (to || w != exp_dly(s)) begin
               bad++; $display("FAIL rnd_wr_wait n=%0d act=%0d exp=%0d", n, w, exp_dly(s)); end
         end else begin
            do_read(s, a, $urandom_range(0, 3), d, rw, vl, ok, to);
            total++; if (to || rw != exp_dly(s) || vl != exp_lat(s) || !ok) begin
               bad++; $display("FAIL rnd_rd_timing n=%0d act=rw%0d vl%0d ok%0d exp=rw%0d vl%0d ok1",
                               n, rw, vl, ok, exp_dly(s), exp_lat(s)); end
            total++; if (d !== mdl[s][widx(a)]) begin
               bad++; $display("FAIL rnd_rd_data n=%0d act=%h exp=%h", n, d, mdl[s][widx(a)]); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_strobe();
      test_timing();
      test_both();
      test_reset_abort();
      test_wrap();
      test_random();
      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
